// File: rtl/divisor_frecuencia_multicanal_pkg.sv
// Shared types and helpers for the multichannel clock divider.
// Holds the per-channel status bundle and the channel-select width rule.
package divisor_frecuencia_multicanal_pkg;

    localparam int N_CANALES_DEF   = 2;
    localparam int ANCHO_DEF       = 8;
    localparam int DIV_INICIAL_DEF = 5;

    typedef struct packed {
        logic pendiente;
        logic clk_out;
        logic tick;
    } canal_sal_t;

    // A single channel still needs a 1-bit selector so the port never collapses.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/divisor_frecuencia_multicanal_if.sv
// Control/status bundle between the divider and its programming master.
// The master drives enables, sync and limit writes; the divider reports back.
interface divisor_frecuencia_multicanal_if
    import divisor_frecuencia_multicanal_pkg::*;
#(
    parameter int N_CANALES = N_CANALES_DEF,
    parameter int ANCHO     = ANCHO_DEF
) ();

    localparam int SEL_W = sel_w(N_CANALES);

    logic [N_CANALES-1:0] en;
    logic                 sinc;
    logic                 div_wr;
    logic [SEL_W-1:0]     div_sel;
    logic [ANCHO-1:0]     div_val;
    logic [N_CANALES-1:0] pendiente;
    logic [N_CANALES-1:0] clk_out;
    logic [N_CANALES-1:0] tick;

    modport master (
        output en,
        output sinc,
        output div_wr,
        output div_sel,
        output div_val,
        input  pendiente,
        input  clk_out,
        input  tick
    );

    modport slave (
        input  en,
        input  sinc,
        input  div_wr,
        input  div_sel,
        input  div_val,
        output pendiente,
        output clk_out,
        output tick
    );

endinterface

// File: rtl/divisor_frecuencia_multicanal_canal.sv
// One divider channel: half-period counter, active/pending limit pair,
// divided clock level and a registered one-cycle tick per edge.
module canal_divisor
    import divisor_frecuencia_multicanal_pkg::*;
#(
    parameter int ANCHO       = ANCHO_DEF,
    parameter int DIV_INICIAL = DIV_INICIAL_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_sinc,
    input  logic             i_wr,
    input  logic [ANCHO-1:0] i_val,
    output canal_sal_t       o_sal
);

    localparam logic [ANCHO-1:0] LIM_RST = ANCHO'(DIV_INICIAL);

    logic [ANCHO-1:0] r_cuenta;
    logic [ANCHO-1:0] r_limite;
    logic [ANCHO-1:0] r_pend_val;
    logic             r_pendiente;
    logic             r_clk_out;
    logic             r_tick;

    logic w_fin;
    logic w_frontera;

    assign w_fin      = i_en && !i_sinc && (r_cuenta == r_limite);
    // Limits may only swap where a half-period starts afresh.
    assign w_frontera = !i_en || i_sinc || w_fin;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cuenta    <= '0;
            r_clk_out   <= 1'b0;
            r_tick      <= 1'b0;
        end else if (!i_en || i_sinc) begin
            r_cuenta    <= '0;
            r_clk_out   <= 1'b0;
            r_tick      <= 1'b0;
        end else if (w_fin) begin
            r_cuenta    <= '0;
            r_clk_out   <= ~r_clk_out;
            r_tick      <= 1'b1;
        end else begin
            r_cuenta    <= r_cuenta + 1'b1;
            r_tick      <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_limite    <= LIM_RST;
            r_pend_val  <= LIM_RST;
            r_pendiente <= 1'b0;
        end else if (i_wr && i_sinc) begin
            // A write coinciding with sync is taken straight into service.
            r_limite    <= i_val;
            r_pend_val  <= i_val;
            r_pendiente <= 1'b0;
        end else begin
            if (w_frontera && r_pendiente) begin
                r_limite <= r_pend_val;
            end
            if (i_wr) begin
                r_pend_val  <= i_val;
                r_pendiente <= 1'b1;
            end else if (w_frontera) begin
                r_pendiente <= 1'b0;
            end
        end
    end

    assign o_sal.pendiente = r_pendiente;
    assign o_sal.clk_out   = r_clk_out;
    assign o_sal.tick      = r_tick;

endmodule

// File: rtl/divisor_frecuencia_multicanal.sv
// Multichannel programmable clock divider: decodes limit writes per channel
// and replicates the channel divider, collecting level, tick and pending flags.
module divisor_frecuencia_multicanal
    import divisor_frecuencia_multicanal_pkg::*;
#(
    parameter int N_CANALES   = N_CANALES_DEF,
    parameter int ANCHO       = ANCHO_DEF,
    parameter int DIV_INICIAL = DIV_INICIAL_DEF
) (
    input logic                       clk,
    input logic                       reset,
    divisor_frecuencia_multicanal_if.slave bus
);

    localparam int SEL_W = sel_w(N_CANALES);

    logic [N_CANALES-1:0] w_wr;
    logic [N_CANALES-1:0] w_pend;
    logic [N_CANALES-1:0] w_clk;
    logic [N_CANALES-1:0] w_tick;

    for (genvar g = 0; g < N_CANALES; g++) begin : g_canal
        canal_sal_t w_sal;

        // Selectors beyond the last channel match no strobe and are dropped.
        assign w_wr[g] = bus.div_wr && (bus.div_sel == SEL_W'(g));

        canal_divisor #(
            .ANCHO       (ANCHO),
            .DIV_INICIAL (DIV_INICIAL)
        ) u_canal (
            .clk    (clk),
            .reset  (reset),
            .i_en   (bus.en[g]),
            .i_sinc (bus.sinc),
            .i_wr   (w_wr[g]),
            .i_val  (bus.div_val),
            .o_sal  (w_sal)
        );

        assign w_pend[g] = w_sal.pendiente;
        assign w_clk[g]  = w_sal.clk_out;
        assign w_tick[g] = w_sal.tick;
    end

    assign bus.pendiente = w_pend;
    assign bus.clk_out   = w_clk;
    assign bus.tick      = w_tick;

endmodule

// File: tb/tb_divisor_frecuencia_multicanal.sv
// Random-stimulus bench: compares every channel output each cycle with a
// timestamp-based model of toggle instants and pending-limit rules.
module tb_divisor_frecuencia_multicanal;
    import divisor_frecuencia_multicanal_pkg::*;

    localparam int NC = 3;
    localparam int AW = 8;
    localparam int DI = 5;
    localparam int SW = sel_w(NC);

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    divisor_frecuencia_multicanal_if #(.N_CANALES(NC), .ANCHO(AW)) bus ();

    divisor_frecuencia_multicanal #(
        .N_CANALES   (NC),
        .ANCHO       (AW),
        .DIV_INICIAL (DI)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    int m_lim   [NC];
    int m_pv    [NC];
    int m_start [NC];
    bit m_pend  [NC];
    bit m_lvl   [NC];
    bit m_tick  [NC];
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Model: a half-period that starts at edge S with limit L ends (tick) at edge S+L.
    task automatic model_step();
        for (int i = 0; i < NC; i++) begin
            bit w, fin, bnd;
            if (reset) begin
                m_lim[i]   = DI;
                m_pv[i]    = DI;
                m_pend[i]  = 0;
                m_lvl[i]   = 0;
                m_tick[i]  = 0;
                m_start[i] = cyc + 1;
                continue;
            end
            w   = bus.div_wr && (int'(bus.div_sel) == i);
            fin = bus.en[i] && !bus.sinc && (cyc == m_start[i] + m_lim[i]);
            bnd = !bus.en[i] || bus.sinc || fin;
            if (!bus.en[i] || bus.sinc) begin
                m_lvl[i]   = 0;
                m_tick[i]  = 0;
                m_start[i] = cyc + 1;
            end else if (fin) begin
                m_lvl[i]   = !m_lvl[i];
                m_tick[i]  = 1;
                m_start[i] = cyc + 1;
            end else begin
                m_tick[i]  = 0;
            end
            if (w && bus.sinc) begin
                m_lim[i]  = int'(bus.div_val);
                m_pv[i]   = int'(bus.div_val);
                m_pend[i] = 0;
            end else begin
                if (bnd && m_pend[i]) begin
                    m_lim[i]  = m_pv[i];
                    m_pend[i] = 0;
                end
                if (w) begin
                    m_pv[i]   = int'(bus.div_val);
                    m_pend[i] = 1;
                end
            end
        end
        cyc++;
    endtask

    task automatic ciclo(input logic r, input logic [NC-1:0] e,
                         input logic s, input logic w,
                         input logic [SW-1:0] sel, input logic [AW-1:0] v);
        logic [NC-1:0] x_clk, x_tick, x_pend;
        @(negedge clk);
        reset       = r;
        bus.en      = e;
        bus.sinc    = s;
        bus.div_wr  = w;
        bus.div_sel = sel;
        bus.div_val = v;
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < NC; i++) begin
            x_clk[i]  = m_lvl[i];
            x_tick[i] = m_tick[i];
            x_pend[i] = m_pend[i];
        end
        chk("clk_out",   32'(bus.clk_out),   32'(x_clk));
        chk("tick",      32'(bus.tick),      32'(x_tick));
        chk("pendiente", 32'(bus.pendiente), 32'(x_pend));
    endtask

    task automatic fase(input int n, input int ep, input int sp,
                        input int wp, input int rp);
        logic [NC-1:0] e;
        e = bus.en;
        for (int k = 0; k < n; k++) begin
            logic [AW-1:0] v;
            if ($urandom_range(0, ep) == 0) e = NC'($urandom);
            if ($urandom_range(0, 15) == 0) v = AW'($urandom_range(0, 40));
            else v = AW'($urandom_range(0, 6));
            ciclo($urandom_range(0, rp) == 0, e,
                  $urandom_range(0, sp) == 0,
                  $urandom_range(0, wp) == 0,
                  SW'($urandom_range(0, 3)), v);
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.en      = '0;
        bus.sinc    = 1'b0;
        bus.div_wr  = 1'b0;
        bus.div_sel = '0;
        bus.div_val = '0;
        for (int k = 0; k < 3; k++) ciclo(1, '0, 0, 0, '0, '0);
        for (int k = 0; k < 30; k++) ciclo(0, 3'b001, 0, 0, '0, '0);
        ciclo(0, 3'b001, 0, 1, 2'd0, 8'd1);
        for (int k = 0; k < 20; k++) ciclo(0, 3'b001, 0, 0, '0, '0);
        ciclo(0, 3'b001, 0, 1, 2'd1, 8'd0);
        for (int k = 0; k < 10; k++) ciclo(0, 3'b011, 0, 0, '0, '0);
        ciclo(0, 3'b011, 0, 1, 2'd0, 8'd3);
        ciclo(0, 3'b011, 0, 1, 2'd0, 8'd7);
        for (int k = 0; k < 40; k++) ciclo(0, 3'b011, 0, 0, '0, '0);
        ciclo(0, 3'b011, 0, 1, 2'd3, 8'd0);
        ciclo(0, 3'b011, 1, 1, 2'd1, 8'd4);
        for (int k = 0; k < 35; k++) ciclo(0, 3'b011, 0, 0, '0, '0);
        ciclo(1, 3'b011, 0, 1, 2'd0, 8'd2);
        for (int k = 0; k < 20; k++) ciclo(0, 3'b011, 0, 0, '0, '0);
        fase(800, 60, 80, 10, 500);
        fase(800, 8, 20, 3, 300);
        fase(800, 200, 400, 25, 1000);
        fase(600, 4, 6, 2, 150);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
